btn_debounce_multi: RTL

Multi-channel debouncer that generalises the single-button debouncer: N independent pushbutton channels, configurable polarity and debounce time in milliseconds, and press, release, long-press and auto-repeat event pulses. A single shared millisecond prescaler paces every channel. It sits between the board button pins and the menu/input FSM of the matrix calculator. It replaces per-button debouncer instances, and auto-repeat drives value increment/decrement.

---
 rtl/btn_debounce_multi_pkg.sv | 9 +
 rtl/btn_debounce_multi_ms_tick_gen.sv | 16 +
 rtl/btn_debounce_multi.sv | 103 ++++++++++
 3 files changed

// File: rtl/btn_debounce_multi_pkg.sv
// btn_pkg: shared types and widths for the multi-channel button debouncer
package btn_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} hold_state_t;
  localparam int DB_W = 8;
  localparam int HOLD_W = 16;
  function automatic int tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction
endpackage

// File: rtl/btn_debounce_multi_ms_tick_gen.sv
// ms_tick_gen: one-cycle tick every DIV clocks, shared by all button channels
module ms_tick_gen #(
  parameter int DIV = 25_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick_o
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign ms_tick_o = cnt_q == CW'(DIV - 1);
  assign cnt_d = ms_tick_o ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel debouncer with press, release, long-press and
// auto-repeat pulses, all channels paced by one shared millisecond tick
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int N_BTN       = 5,
  parameter int CLK_HZ      = 25_000_000,
  parameter int DEBOUNCE_MS = 15,
  parameter int LONG_MS     = 800,
  parameter int REPEAT_MS   = 150,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);
  localparam int TICK_DIV = tick_div(CLK_HZ);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MS - DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST = HOLD_W'(REPEAT_MS - 1);
  logic ms_tick;
  ms_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .ms_tick_o(ms_tick)
  );
  genvar c;
  for (c = 0; c < N_BTN; c++) begin : g_ch
    logic sync1_q, sync2_q, level_q, level_d, prev_q, db_hit;
    logic press_q, rel_q, long_q, rep_q;
    logic [DB_W-1:0] db_q, db_d;
    logic [HOLD_W-1:0] hold_q;
    hold_state_t st_q;
    always_comb begin
      db_hit = ms_tick && sync2_q != level_q && db_q == DB_LAST;
      level_d = db_hit ? sync2_q : level_q;
      db_d = (sync2_q == level_q || db_hit) ? '0 : db_q + DB_W'(ms_tick);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= '0;
        level_q <= 1'b0;
        prev_q  <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync1_q <= btn_in[c] ^ ACTIVE_LOW;
        sync2_q <= sync1_q;
        db_q    <= db_d;
        level_q <= level_d;
        prev_q  <= level_q;
        press_q <= level_q & ~prev_q;
        rel_q   <= ~level_q & prev_q;
      end
    // The next-state level is checked first so a release landing on a tick suppresses long/repeat
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st_q   <= IDLE;
        hold_q <= '0;
        long_q <= 1'b0;
        rep_q  <= 1'b0;
      end else begin
        long_q <= 1'b0;
        rep_q  <= 1'b0;
        if (!level_d) begin
          st_q   <= IDLE;
          hold_q <= '0;
        end else begin
          case (st_q)
            IDLE: if (level_q && !prev_q) st_q <= HOLD;
            HOLD:
              if (ms_tick) begin
                if (hold_q == LONG_LAST) begin
                  long_q <= 1'b1;
                  hold_q <= '0;
                  st_q   <= REPEAT;
                end else hold_q <= hold_q + HOLD_W'(1);
              end
            REPEAT:
              if (ms_tick && REPEAT_MS != 0) begin
                if (hold_q == REP_LAST) begin
                  rep_q  <= 1'b1;
                  hold_q <= '0;
                end else hold_q <= hold_q + HOLD_W'(1);
              end
            default: st_q <= IDLE;
          endcase
        end
      end
    assign btn_level[c]     = level_q;
    assign press_pulse[c]   = press_q;
    assign release_pulse[c] = rel_q;
    assign long_pulse[c]    = long_q;
    assign repeat_pulse[c]  = rep_q;
  end
endmodule
